ts_fifo_reader: RTL and testbench

TS_FIFO_READER -- requirements
Module: ts_fifo_reader

---
 rtl/ts_fifo_reader_pkg.sv | 13 +
 rtl/ts_fifo_reader_sat.sv | 24 ++
 rtl/ts_fifo_reader.sv | 106 ++++++++++
 tb/tb_ts_fifo_reader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/ts_fifo_reader_pkg.sv
// Shared link-engine timestamp definitions: state encoding, timestamp width
// and default post-pop holdoff.
package ts_fifo_reader_pkg;
  localparam int TS_W            = 108;
  localparam int HOLDOFF_DEFAULT = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;
endpackage

// File: rtl/ts_fifo_reader_sat.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count = cnt_q;
endmodule

// File: rtl/ts_fifo_reader.sv
// Releases the head-of-FIFO timestamp once local time reaches it, pops the
// FIFO, and then waits a holdoff so the FIFO head can settle.
module ts_fifo_reader
  import ts_fifo_reader_pkg::*;
#(
  parameter int HOLDOFF = HOLDOFF_DEFAULT,
  parameter int TIME_W  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iENABLE,
  input  logic [TIME_W-1:0] iCUR_TIME,
  input  logic [TS_W-1:0]   iFUTURE_TS,
  input  logic              iFTS_VALID,
  output logic              oTS_FIFO_POP,
  output logic              oRELEASE,
  output logic [TS_W-1:0]   oRELEASE_TS,
  output logic [31:0]       oREG_RELEASE_CNT,
  output logic [15:0]       oREG_LATE_CNT,
  output logic [1:0]        oREG_STATE
);
  localparam int HW        = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);
  localparam int HOLD_LAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

  state_e            state_q, state_d;
  logic [TS_W-1:0]   target_q, target_d;
  logic [TS_W-1:0]   rel_ts_q, rel_ts_d;
  logic              late_q, late_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic              fire;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    rel_ts_d = rel_ts_q;
    late_d   = late_q;
    hold_d   = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (iENABLE && iFTS_VALID) begin
          state_d  = ST_ARMED;
          target_d = iFUTURE_TS;
          late_d   = (iCUR_TIME >= iFUTURE_TS[TIME_W-1:0]);
        end
      end
      ST_ARMED: begin
        // Abort wins over fire so a pop never follows a cycle with no valid head.
        if (!iFTS_VALID || !iENABLE) begin
          state_d = ST_IDLE;
        end else if (iCUR_TIME >= target_q[TIME_W-1:0]) begin
          state_d  = ST_FIRE;
          rel_ts_d = target_q;
        end
      end
      ST_FIRE: begin
        state_d = ST_HOLD;
        hold_d  = '0;
      end
      ST_HOLD: begin
        if (hold_q == HW'(HOLD_LAST)) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      rel_ts_q <= '0;
      late_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rel_ts_q <= rel_ts_d;
      late_q   <= late_d;
      hold_q   <= hold_d;
    end
  end

  assign fire         = (state_q == ST_FIRE);
  assign oTS_FIFO_POP = fire;
  assign oRELEASE     = fire;
  assign oRELEASE_TS  = rel_ts_q;
  assign oREG_STATE   = state_q;

  sat_counter #(.W(32)) u_rel_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fire),
    .count (oREG_RELEASE_CNT)
  );

  sat_counter #(.W(16)) u_late_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (fire && late_q),
    .count (oREG_LATE_CNT)
  );
endmodule

// File: tb/tb_ts_fifo_reader.sv
// Directed bench for ts_fifo_reader: stimulus pushes expected releases into a
// scoreboard queue; a monitor pops and checks each observed release.
module tb_ts_fifo_reader;
  localparam int TIME_W = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          iENABLE = 1'b1;
  logic [63:0]   iCUR_TIME = '0;
  logic [107:0]  iFUTURE_TS = '0;
  logic          iFTS_VALID = 1'b0;
  logic          oTS_FIFO_POP;
  logic          oRELEASE;
  logic [107:0]  oRELEASE_TS;
  logic [31:0]   oREG_RELEASE_CNT;
  logic [15:0]   oREG_LATE_CNT;
  logic [1:0]    oREG_STATE;

  ts_fifo_reader #(.HOLDOFF(3), .TIME_W(TIME_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .iENABLE          (iENABLE),
    .iCUR_TIME        (iCUR_TIME),
    .iFUTURE_TS       (iFUTURE_TS),
    .iFTS_VALID       (iFTS_VALID),
    .oTS_FIFO_POP     (oTS_FIFO_POP),
    .oRELEASE         (oRELEASE),
    .oRELEASE_TS      (oRELEASE_TS),
    .oREG_RELEASE_CNT (oREG_RELEASE_CNT),
    .oREG_LATE_CNT    (oREG_LATE_CNT),
    .oREG_STATE       (oREG_STATE)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [107:0] ts;
    int           at_cyc;
    logic [31:0]  rel;
    logic [15:0]  late;
  } exp_t;

  exp_t         exp_q[$];
  logic [107:0] fifo_q[$];
  bit           ramp = 0;
  int           checks = 0;
  int           errors = 0;

  localparam logic [107:0] TS1  = {44'h0000_0000_A01, 64'd100};
  localparam logic [107:0] TS2  = {44'h0000_0000_B02, 64'd50};
  localparam logic [107:0] TS3A = {44'h0000_0000_C03, 64'd10};
  localparam logic [107:0] TS3B = {44'h0000_0000_C04, 64'd11};
  localparam logic [107:0] TS4  = {44'h0000_0000_D05, 64'd1000};
  localparam logic [107:0] TS5  = {44'h0000_0000_E06, 64'd5};
  localparam logic [107:0] TS6  = {44'h0000_0000_F07, 64'd7};
  localparam logic [107:0] TS7  = {44'h0000_0000_F08, 64'd8};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    iFTS_VALID = (fifo_q.size() != 0);
    iFUTURE_TS = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  // One cycle of the FIFO/time model: advance to the next falling edge.
  task automatic tick();
    @(negedge clk);
    if (oTS_FIFO_POP && fifo_q.size() > 0) void'(fifo_q.pop_front());
    refresh();
    if (ramp) iCUR_TIME = iCUR_TIME + 64'd1;
  endtask

  task automatic expect_rel(input logic [107:0] ts, input int dcyc,
                            input logic [31:0] rel, input logic [15:0] late);
    exp_t e;
    e.ts = ts; e.at_cyc = cyc + dcyc; e.rel = rel; e.late = late;
    exp_q.push_back(e);
    $display("stim: ts=%0h expect release at cycle %0d rel=%0d late=%0h", ts, e.at_cyc, rel, late);
  endtask

  // Monitor: every observed release must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (oRELEASE || oTS_FIFO_POP) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_release", {oRELEASE, oTS_FIFO_POP}, 0);
        end else begin
          e = exp_q.pop_front();
          $display("mon: release ts=%0h at cycle %0d", oRELEASE_TS, cyc);
          chk("pop", oTS_FIFO_POP, 1);
          chk("release", oRELEASE, 1);
          chk("release_ts", oRELEASE_TS, e.ts);
          chk("release_cycle", cyc, e.at_cyc);
          @(negedge clk);
          chk("release_cnt", oREG_RELEASE_CNT, e.rel);
          chk("late_cnt", oREG_LATE_CNT, e.late);
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_state", oREG_STATE, 0);
    chk("rst_pop", oTS_FIFO_POP, 0);
    chk("rst_release", oRELEASE, 0);
    chk("rst_ts", oRELEASE_TS, 0);
    chk("rst_rel_cnt", oREG_RELEASE_CNT, 0);
    chk("rst_late_cnt", oREG_LATE_CNT, 0);
    rst = 1'b0;
    tick();

    // On-time release: time ramps 90 upward, target 100.
    iCUR_TIME = 64'd90;
    fifo_q.push_back(TS1); refresh();
    expect_rel(TS1, 11, 32'd1, 16'd0);
    ramp = 1;
    repeat (16) tick();
    ramp = 0;
    chk("t1_idle", oREG_STATE, 0);
    chk("t1_ts_hold", oRELEASE_TS, TS1);

    // Late release: target 50 with time already 80.
    iCUR_TIME = 64'd80;
    fifo_q.push_back(TS2); refresh();
    expect_rel(TS2, 2, 32'd2, 16'd1);
    repeat (8) tick();

    // Back-to-back targets after a fresh reset: pops 6 cycles apart.
    rst = 1'b1;
    tick();
    chk("t3_rst_rel_cnt", oREG_RELEASE_CNT, 0);
    rst = 1'b0;
    iCUR_TIME = 64'd20;
    fifo_q.push_back(TS3A); fifo_q.push_back(TS3B); refresh();
    expect_rel(TS3A, 2, 32'd1, 16'd1);
    expect_rel(TS3B, 8, 32'd2, 16'd2);
    repeat (14) tick();

    // Abort from ARMED when valid drops, then when enable drops.
    iCUR_TIME = 64'd500;
    fifo_q.push_back(TS4); refresh();
    tick();
    chk("t4_armed", oREG_STATE, 1);
    fifo_q.delete(); refresh();
    tick();
    chk("t4_valid_abort", oREG_STATE, 0);
    fifo_q.push_back(TS4); refresh();
    tick();
    chk("t4_rearmed", oREG_STATE, 1);
    iENABLE = 1'b0;
    tick();
    chk("t4_enable_abort", oREG_STATE, 0);
    fifo_q.delete(); refresh();
    iENABLE = 1'b1;
    repeat (6) tick();
    chk("t4_rel_cnt", oREG_RELEASE_CNT, 2);
    chk("t4_late_cnt", oREG_LATE_CNT, 2);
    chk("t4_ts_hold", oRELEASE_TS, TS3B);

    // Late counter saturation.
    force dut.u_late_cnt.cnt_q = 16'hFFFF;
    tick();
    release dut.u_late_cnt.cnt_q;
    tick();
    chk("t5_preload", oREG_LATE_CNT, 16'hFFFF);
    iCUR_TIME = 64'd20;
    fifo_q.push_back(TS5); refresh();
    expect_rel(TS5, 2, 32'd3, 16'hFFFF);
    repeat (8) tick();

    // Reset pulsed during HOLD.
    fifo_q.push_back(TS6); refresh();
    expect_rel(TS6, 2, 32'd4, 16'hFFFF);
    repeat (4) tick();
    chk("t6_in_hold", oREG_STATE, 3);
    rst = 1'b1;
    tick();
    chk("t6_state", oREG_STATE, 0);
    chk("t6_pop", oTS_FIFO_POP, 0);
    chk("t6_release", oRELEASE, 0);
    chk("t6_ts", oRELEASE_TS, 0);
    chk("t6_rel_cnt", oREG_RELEASE_CNT, 0);
    chk("t6_late_cnt", oREG_LATE_CNT, 0);
    rst = 1'b0;
    repeat (8) tick();
    chk("t6_still_idle", oREG_STATE, 0);
    fifo_q.push_back(TS7); refresh();
    expect_rel(TS7, 2, 32'd1, 16'd1);
    repeat (8) tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
